// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared register-file geometry and scoreboard constants
package wb_regfile_pkg;
    localparam int DATA_W = 20;
    localparam int NREG   = 16;
    localparam int REG_AW = 4;
    localparam int PEND_W = 2;
    localparam logic [REG_AW-1:0] R0       = '0;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
endpackage

// File: rtl/wb_pend_ctr.sv
// wb_pend_ctr: per-register outstanding-write counter with underflow flag
module wb_pend_ctr
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              underflow
);
    logic [PEND_W-1:0] cnt_q, cnt_d;

    always_comb begin
        underflow = dec && !inc && cnt_q == '0;
        cnt_d     = (inc && !dec) ? cnt_q + 1'b1
                  : (dec && !inc && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 16x20 register file with writeback bypass and RAW scoreboard
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              RW,
    input  logic [REG_AW-1:0] Dest,
    input  logic [DATA_W-1:0] WBData,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              iss_valid,
    input  logic              iss_rs_used,
    input  logic              iss_rt_used,
    input  logic              iss_wr,
    input  logic [REG_AW-1:0] iss_dest,
    output logic              stall,
    output logic [NREG-1:0]   busy,
    output logic              wb_err
);
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [PEND_W-1:0] pend [NREG];
    logic [NREG-1:1]   uflow;
    logic              wb, acc, wb_err_q, wb_err_d;

    // A writeback during reset must neither land nor bypass.
    assign wb = RW && !rst && Dest != R0;

    function automatic logic src_busy(input logic [REG_AW-1:0] a);
        return a != R0 && pend[a] != '0 && !(wb && Dest == a && pend[a] == PEND_W'(1));
    endfunction

    always_comb begin
        stall = iss_valid && ((iss_rs_used && src_busy(rs_addr)) ||
                              (iss_rt_used && src_busy(rt_addr)) ||
                              (iss_wr && iss_dest != R0 && pend[iss_dest] == PEND_MAX));
        acc      = iss_valid && !stall && iss_wr && iss_dest != R0;
        rs_data  = rs_addr == R0 ? '0 : (wb && Dest == rs_addr) ? WBData : regs_q[rs_addr];
        rt_data  = rt_addr == R0 ? '0 : (wb && Dest == rt_addr) ? WBData : regs_q[rt_addr];
        regs_d   = regs_q;
        if (wb) regs_d[Dest] = WBData;
        wb_err_d = wb_err_q || |uflow;
    end

    assign pend[0] = '0;
    assign busy[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_ctr
        wb_pend_ctr u_ctr (
            .clk       (clk),
            .rst       (rst),
            .inc       (acc && iss_dest == REG_AW'(i)),
            .dec       (wb && Dest == REG_AW'(i)),
            .cnt       (pend[i]),
            .underflow (uflow[i])
        );
        assign busy[i] = pend[i] != '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
            wb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign wb_err = wb_err_q;
endmodule
